// File: rtl/ctrl_encode_def.sv
// ctrl_encode_def
// Shared control encodings for the CPU datapath. The DMType codes select the
// size and extension of a load/store and are produced by ctrl and consumed by
// the data-memory responder.
// No ports: package only.
package ctrl_encode_def;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    // Codes outside the byte/halfword set behave as word accesses.
    function automatic logic dm_is_half(input logic [2:0] t);
        return (t == dm_halfword) || (t == dm_halfword_unsigned);
    endfunction

    function automatic logic dm_is_byte(input logic [2:0] t);
        return (t == dm_byte) || (t == dm_byte_unsigned);
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align
// Combinational lane steering for sized memory accesses.
// Ports:
//   i_dmtype      access size / extension code
//   i_addr_lo     byte offset within the word (Addr[1:0])
//   i_wdata       store data from the CPU
//   i_rword       full 32-bit word read from the array
//   o_be          byte enables for the store (all zero when misaligned)
//   o_wdata       store data replicated across the lanes
//   o_rdata       extracted and extended load data (zero when misaligned)
//   o_misaligned  access is not naturally aligned
module dm_lane_align
    import ctrl_encode_def::*;
(
    input  logic [2:0]  i_dmtype,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic       w_half;
    logic       w_byte;
    logic [7:0] w_byte_sel;
    logic [15:0] w_half_sel;

    assign w_half     = dm_is_half(i_dmtype);
    assign w_byte     = dm_is_byte(i_dmtype);
    assign w_byte_sel = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half_sel = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    assign o_misaligned = (w_half && i_addr_lo[0]) ||
                          (!w_half && !w_byte && (i_addr_lo != 2'b00));

    // Store lanes are replicated so the byte enables alone pick the target
    // bytes; misaligned accesses get no enables and read back as zero.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = 32'h0;
        if (!o_misaligned) begin
            if (w_byte) begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_dmtype == dm_byte_unsigned) ? {24'h0, w_byte_sel}
                                                         : {{24{w_byte_sel[7]}}, w_byte_sel};
            end else if (w_half) begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = (i_dmtype == dm_halfword_unsigned) ? {16'h0, w_half_sel}
                                                             : {{16{w_half_sel[15]}}, w_half_sel};
            end else begin
                o_be    = 4'b1111;
                o_rdata = i_rword;
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder
// Data-memory responder for the CPU load/store port: one sized access at a
// time, WAIT_CYCLES wait states, then a one-cycle MIO_ready acknowledge.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   mem_r      read request
//   mem_w      write request (wins over mem_r)
//   Addr_in    byte address
//   Data_in    store data
//   DMType     access size / extension
//   Data_out   registered load data, held until the next read acknowledge
//   MIO_ready  one-cycle completion pulse
//   mis_err    misaligned flag, meaningful while MIO_ready is high
module dm_responder
    import ctrl_encode_def::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic        mis_err
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [2:0]         r_type;
    logic               r_is_write;
    logic [31:0]        r_dout;
    logic               r_mis;
    logic               r_live;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_req;
    logic               w_in_idle;
    logic               w_commit;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [2:0]         w_type;
    logic               w_write;
    logic [AW-1:0]      w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wrep;
    logic [31:0]        w_rdata;
    logic               w_mis;
    logic               w_unused_addr;

    // r_live keeps the first edge after reset release from sampling a request,
    // so no access (and no array write) can start while reset is asserted.
    assign w_req     = r_live && (mem_r || mem_w);
    assign w_in_idle = (r_state == S_IDLE);

    // With zero wait states the access completes on its sampling edge, before
    // the latched copy exists, so the live inputs feed the datapath in IDLE.
    assign w_addr  = w_in_idle ? Addr_in : r_addr;
    assign w_wdata = w_in_idle ? Data_in : r_wdata;
    assign w_type  = w_in_idle ? DMType  : r_type;
    assign w_write = w_in_idle ? mem_w   : r_is_write;

    assign w_idx         = w_addr[AW+1:2];
    assign w_unused_addr = ^w_addr[31:AW+2];
    assign w_commit      = (w_next == S_ACK);

    dm_lane_align u_lane (
        .i_dmtype     (w_type),
        .i_addr_lo    (w_addr[1:0]),
        .i_wdata      (w_wdata),
        .i_rword      (r_mem[w_idx]),
        .o_be         (w_be),
        .o_wdata      (w_wrep),
        .o_rdata      (w_rdata),
        .o_misaligned (w_mis)
    );

    // Next-state logic: ACK never samples requests and always falls to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_next = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
            S_WAIT: if (r_cnt <= CNT_W'(1)) w_next = S_ACK;
            S_ACK:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, request latch, wait counter and registered read result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_type     <= dm_word;
            r_is_write <= 1'b0;
            r_dout     <= 32'h0;
            r_mis      <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next;
            r_mis   <= w_commit && w_mis;
            if (w_in_idle && w_req) begin
                r_addr     <= Addr_in;
                r_wdata    <= Data_in;
                r_type     <= DMType;
                r_is_write <= mem_w;
                r_cnt      <= CNT_W'(WAIT_CYCLES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_commit && !w_write) begin
                r_dout <= w_rdata;
            end
        end
    end

    // Data array: not reset; written only on the edge that enters ACK.
    always_ff @(posedge clk) begin
        if (w_commit && w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
        end
    end

    assign Data_out  = r_dout;
    assign MIO_ready = (r_state == S_ACK);
    assign mis_err   = r_mis;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder
// Two responders: dut 0 with two wait states, dut 1 with zero wait states.
// Stimulus pushes the expected acknowledge into a per-dut queue; independent
// monitors pop and compare whenever MIO_ready is seen.
module tb_dm_responder;
    import ctrl_encode_def::*;

    localparam int WAIT0 = 2;
    localparam int WAIT1 = 0;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        memR     [2];
    logic        memW     [2];
    logic [31:0] addrIn   [2];
    logic [31:0] dataIn   [2];
    logic [2:0]  dmType   [2];
    logic [31:0] dataOut  [2];
    logic        mioReady [2];
    logic        misErr   [2];

    exp_t expQ0 [$];
    exp_t expQ1 [$];
    exp_t mon0;
    exp_t mon1;
    time  sampleTime [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT0)) dut0 (
        .clk(clk), .rst(rst[0]), .mem_r(memR[0]), .mem_w(memW[0]),
        .Addr_in(addrIn[0]), .Data_in(dataIn[0]), .DMType(dmType[0]),
        .Data_out(dataOut[0]), .MIO_ready(mioReady[0]), .mis_err(misErr[0])
    );

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT1)) dut1 (
        .clk(clk), .rst(rst[1]), .mem_r(memR[1]), .mem_w(memW[1]),
        .Addr_in(addrIn[1]), .Data_in(dataIn[1]), .DMType(dmType[1]),
        .Data_out(dataOut[1]), .MIO_ready(mioReady[1]), .mis_err(misErr[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor for dut 0: every acknowledge must match the oldest expectation.
    always @(negedge clk) begin
        if (mioReady[0] === 1'b1) begin
            if (expQ0.size() == 0) begin
                checkOutput("dut0 unexpected MIO_ready", {31'h0, mioReady[0]}, 32'h0);
            end else begin
                mon0 = expQ0.pop_front();
                checkOutput({mon0.name, " Data_out"}, dataOut[0], mon0.data);
                checkOutput({mon0.name, " mis_err"}, {31'h0, misErr[0]}, {31'h0, mon0.mis});
            end
        end
    end

    // Monitor for dut 1.
    always @(negedge clk) begin
        if (mioReady[1] === 1'b1) begin
            if (expQ1.size() == 0) begin
                checkOutput("dut1 unexpected MIO_ready", {31'h0, mioReady[1]}, 32'h0);
            end else begin
                mon1 = expQ1.pop_front();
                checkOutput({mon1.name, " Data_out"}, dataOut[1], mon1.data);
                checkOutput({mon1.name, " mis_err"}, {31'h0, misErr[1]}, {31'h0, mon1.mis});
            end
        end
    end

    // Issue one access, check the acknowledge latency, then release the
    // request in the cycle after ACK so the next call samples on the next edge.
    task automatic applyStimulus(input int d, input logic wr, input logic rd,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [2:0] t, input logic [31:0] expData,
                                 input logic expMis, input string name);
        exp_t e;
        int   n;
        logic got;
        int   expLat;
        e.data = expData;
        e.mis  = expMis;
        e.name = name;
        expLat = (d == 0) ? WAIT0 + 1 : WAIT1 + 1;
        if (d == 0) expQ0.push_back(e); else expQ1.push_back(e);
        memR[d]   = rd;
        memW[d]   = wr;
        addrIn[d] = a;
        dataIn[d] = wd;
        dmType[d] = t;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            if (n == 1) sampleTime[d] = $time;
            #1;
            if (mioReady[d] === 1'b1) got = 1'b1;
        end
        checkOutput({name, " latency"}, n, expLat);
        if (!got) begin
            if (d == 0) e = expQ0.pop_back(); else e = expQ1.pop_back();
        end
        @(posedge clk);
        #1;
        memR[d] = 1'b0;
        memW[d] = 1'b0;
    endtask

    // Start a store on dut 0 and assert reset during its first wait state.
    task automatic resetDuringWait(input logic [31:0] a, input logic [31:0] wd);
        int pulses;
        memW[0]   = 1'b1;
        memR[0]   = 1'b0;
        addrIn[0] = a;
        dataIn[0] = wd;
        dmType[0] = dm_word;
        @(posedge clk);
        #1;
        rst[0]  = 1'b0;
        memW[0] = 1'b0;
        @(negedge clk);
        checkOutput("mid-reset MIO_ready", {31'h0, mioReady[0]}, 32'h0);
        checkOutput("mid-reset Data_out", dataOut[0], 32'h0);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (mioReady[0] === 1'b1) pulses++;
        end
        checkOutput("reset-in-wait pulses", pulses, 32'h0);
    endtask

    initial begin
        time t0;
        for (int i = 0; i < 2; i++) begin
            rst[i]    = 1'b0;
            memR[i]   = 1'b0;
            memW[i]   = 1'b0;
            addrIn[i] = 32'h0;
            dataIn[i] = 32'h0;
            dmType[i] = dm_word;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset dut0 MIO_ready", {31'h0, mioReady[0]}, 32'h0);
        checkOutput("reset dut0 Data_out", dataOut[0], 32'h0);
        checkOutput("reset dut0 mis_err", {31'h0, misErr[0]}, 32'h0);
        checkOutput("reset dut1 MIO_ready", {31'h0, mioReady[1]}, 32'h0);
        checkOutput("reset dut1 Data_out", dataOut[1], 32'h0);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // dut 0: two wait states
        applyStimulus(0, 1, 0, 32'h00, 32'h00000000, dm_word,              32'h00000000, 0, "sw 0x0");
        applyStimulus(0, 0, 1, 32'h00, 32'h0,        dm_word,              32'h00000000, 0, "lw 0x0");
        applyStimulus(0, 1, 0, 32'h10, 32'h11223344, dm_word,              32'h00000000, 0, "sw 0x10");
        applyStimulus(0, 1, 0, 32'h13, 32'h123456AB, dm_byte,              32'h00000000, 0, "sb 0x13");
        applyStimulus(0, 0, 1, 32'h10, 32'h0,        dm_word,              32'hAB223344, 0, "lw 0x10");
        applyStimulus(0, 0, 1, 32'h13, 32'h0,        dm_byte,              32'hFFFFFFAB, 0, "lb 0x13");
        applyStimulus(0, 0, 1, 32'h13, 32'h0,        dm_byte_unsigned,     32'h000000AB, 0, "lbu 0x13");
        applyStimulus(0, 0, 1, 32'h12, 32'h0,        dm_halfword,          32'hFFFFAB22, 0, "lh 0x12");
        applyStimulus(0, 0, 1, 32'h12, 32'h0,        dm_halfword_unsigned, 32'h0000AB22, 0, "lhu 0x12");
        applyStimulus(0, 0, 1, 32'h10, 32'h0,        dm_halfword,          32'h00003344, 0, "lh 0x10");
        applyStimulus(0, 1, 0, 32'h20, 32'h00000000, dm_word,              32'h00003344, 0, "sw 0x20");
        applyStimulus(0, 1, 0, 32'h21, 32'h0000BEEF, dm_halfword,          32'h00003344, 1, "sh 0x21 misaligned");
        applyStimulus(0, 0, 1, 32'h20, 32'h0,        dm_word,              32'h00000000, 0, "lw 0x20");
        applyStimulus(0, 0, 1, 32'h22, 32'h0,        dm_word,              32'h00000000, 1, "lw 0x22 misaligned");
        applyStimulus(0, 0, 1, 32'h10, 32'h0,        dm_word,              32'hAB223344, 0, "lw 0x10 again");
        applyStimulus(0, 1, 1, 32'h40, 32'h00000007, dm_word,              32'hAB223344, 0, "r+w 0x40");
        applyStimulus(0, 0, 1, 32'h40, 32'h0,        dm_word,              32'h00000007, 0, "lw 0x40");
        applyStimulus(0, 1, 0, 32'h42, 32'h1234CAFE, dm_halfword,          32'h00000007, 0, "sh 0x42");
        applyStimulus(0, 0, 1, 32'h40, 32'h0,        3'b111,               32'hCAFE0007, 0, "lw(undef) 0x40");
        applyStimulus(0, 1, 0, 32'h30, 32'h12345678, dm_word,              32'hCAFE0007, 0, "sw 0x30");
        resetDuringWait(32'h30, 32'h00000055);
        applyStimulus(0, 0, 1, 32'h30, 32'h0,        dm_word,              32'h12345678, 0, "lw 0x30 after reset");

        // dut 1: zero wait states, address wrap-around, back-to-back
        applyStimulus(1, 1, 0, 32'h1000, 32'hDEADBEEF, dm_word,          32'h00000000, 0, "z sw 0x1000");
        t0 = sampleTime[1];
        applyStimulus(1, 0, 1, 32'h0000, 32'h0,        dm_word,          32'hDEADBEEF, 0, "z lw 0x0");
        checkOutput("z back-to-back period", 32'(sampleTime[1] - t0), 32'd20);
        applyStimulus(1, 0, 1, 32'h1001, 32'h0,        dm_byte,          32'hFFFFFFBE, 0, "z lb 0x1001");
        applyStimulus(1, 0, 1, 32'h1001, 32'h0,        dm_byte_unsigned, 32'h000000BE, 0, "z lbu 0x1001");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("dut0 queue drained", expQ0.size(), 32'h0);
        checkOutput("dut1 queue drained", expQ1.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder on the far end of the CPU's load/store port. Accepts one sized read or write request at a time, handling byte, halfword and word accesses with sign or zero extension. Inserts a configurable number of wait states and signals completion with a one-cycle `MIO_ready` pulse, which the pipelined CPU uses to stall its MEM stage. Holds the data array internally and replaces the zero-latency behavioural data memory.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two.
- `WAIT_CYCLES`, default 2: wait states inserted before every acknowledge; 0 is legal.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `mem_r` in 1: read request.
- `mem_w` in 1: write request.
- `Addr_in` in 32: byte address.
- `Data_in` in 32: write data; the low byte or low halfword is used for sub-word stores.
- `DMType` in 3: access size and extension.
- `Data_out` out 32: read data, extended to 32 bits.
- `MIO_ready` out 1: one-cycle completion pulse.
- `mis_err` out 1: misaligned-access flag, valid only while `MIO_ready` is high.

## Operation
- States are IDLE, WAIT and ACK.
- IDLE:
  - A request is `mem_r | mem_w` high on a rising edge.
  - On a request, latch `Addr_in`, `Data_in`, `DMType` and the read/write direction.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or straight to ACK if `WAIT_CYCLES` = 0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, the next edge goes to ACK.
  - Inputs are ignored; only the latched copy is used.
- ACK:
  - `MIO_ready` = 1 for exactly one cycle.
  - The next edge always returns to IDLE. There is no request sampling in ACK.
- Write commit: the array is updated on the edge that enters ACK, using byte enables from `DMType` and `Addr[1:0]`:
  - sb writes 1 byte.
  - sh writes 2 bytes.
  - sw writes 4 bytes.
- Read data:
  - `Data_out` is registered on the edge that enters ACK.
  - It holds that value until the next ACK.
  - Byte or halfword is selected by `Addr[1:0]`.
  - lb and lh sign-extend; lbu and lhu zero-extend.
- Word index: `Addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap around the array.
- Misalignment:
  - Halfword with `Addr[0]` = 1, or word with `Addr[1:0]` ≠ 0, is misaligned.
  - The write is suppressed and read data is 0.
  - `mis_err` = 1 during ACK.
- Simultaneous `mem_r` and `mem_w`: the access is a write and `Data_out` is unchanged.
- Undefined `DMType` codes are treated as word.
- Initiator rule: hold the request through the ACK cycle and drop it or present the next one afterwards. A request seen in IDLE is always a new request.

## Timing
- Latency: `MIO_ready` rises `WAIT_CYCLES`+1 cycles after the sampling edge.
- Minimum access period is `WAIT_CYCLES`+2 cycles.
- Reset values: state IDLE, `MIO_ready` = 0, `mis_err` = 0, `Data_out` = 0, counter 0.
- Reset asserted mid-access:
  - Return to IDLE immediately.
  - No write is committed unless the commit edge has already occurred.
  - Array contents are not reset.
- Read data reflects all writes completed before the read's ACK, so read-after-write is consistent.

## Structure
- `DMType` constants belong in the shared `ctrl_encode_def` package, also used by `ctrl`:
  - `dm_word` = 3'b000
  - `dm_halfword` = 3'b001
  - `dm_halfword_unsigned` = 3'b010
  - `dm_byte` = 3'b011
  - `dm_byte_unsigned` = 3'b100
- State encodings stay local to this block.
- One sub-module, `dm_lane_align`: combinational byte-enable generation, write-data lane replication and read extract/extend, driven by `DMType` and `Addr[1:0]`.
- The FSM, counter and array stay in `dm_responder`.

## Test plan
- Reset: with `rst` low, then released, expect `MIO_ready` = 0 and `Data_out` = 0. Then a `WAIT_CYCLES` = 2 read of address 0x0 pulses `MIO_ready` exactly 3 cycles after the sampling edge.
- Sized stores and loads:
  - Setup: sw 0x11223344 to 0x10, then sb 0xAB to 0x13.
  - lw 0x10 returns 0xAB223344.
  - lb 0x13 returns 0xFFFFFFAB.
  - lbu 0x13 returns 0x000000AB.
  - lh 0x12 returns 0xFFFFAB22.
- Misaligned accesses:
  - sh to 0x21 gives `mis_err` = 1 in ACK, and a later lw 0x20 returns its prior value 0x00000000.
  - lw 0x22 returns 0 with `mis_err` = 1.
- Wrap-around and zero wait (`DEPTH_WORDS` = 1024, `WAIT_CYCLES` = 0): sw 0xDEADBEEF to 0x1000, then lw 0x0 returns 0xDEADBEEF. `MIO_ready` comes 1 cycle after each sample, and back-to-back requests complete every 2 cycles.
- Reset during WAIT: sw 0x55 to 0x30 with reset asserted in the first WAIT cycle. `MIO_ready` never pulses, and lw 0x30 after reset returns the old value.
- Simultaneous `mem_r` and `mem_w` to 0x40 with data 0x7 is treated as a write: `Data_out` is unchanged, and a later lw 0x40 returns 0x7.
